// File: rtl/maxpool2x2_engine_if.sv
// Handshake and buffer ports of the 2x2 max-pool layer engine.
// master = sequencer/buffer side, slave = engine side.
interface maxpool2x2_engine_if #(
    parameter int DATA_W = 32,
    parameter int IN_AW  = 6,
    parameter int OUT_AW = 4
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     rd_en;
    logic [IN_AW-1:0]         rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [OUT_AW-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;

    modport master (
        output start, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/maxpool2x2_engine.sv
// 2x2 stride-2 signed max pool over an IN_DIM x IN_DIM map, one window per 5 cycles.
// Optional macro MAXPOOL_FUSED_RELU_EN clamps negative pooled results to 0.
module maxpool2x2_engine #(
    parameter int DATA_W = 32,
    parameter int IN_DIM = 6,
    parameter int IN_AW  = 6,
    parameter int OUT_AW = 4
) (
    input  logic                clk,
    input  logic                rst,
    maxpool2x2_engine_if.slave  bus
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_DIM - 1);

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, COMMIT, DONE} state_t;

    state_t                   state, state_next;
    logic [CW-1:0]            win_r, win_c;
    logic signed [DATA_W-1:0] run_max;
    logic signed [DATA_W-1:0] rd_sample;
    logic signed [DATA_W-1:0] pooled;
    logic signed [DATA_W-1:0] pooled_out;
    logic [IN_AW-1:0]         win_base;
    logic [OUT_AW-1:0]        win_out_addr;

    logic [IN_AW-1:0]         rd_addr_q;
    logic [OUT_AW-1:0]        wr_addr_q;
    logic signed [DATA_W-1:0] wr_data_q;

    logic                     busy_c, done_c, rd_en_c, wr_en_c;
    logic [IN_AW-1:0]         rd_addr_c;
    logic [OUT_AW-1:0]        wr_addr_c;
    logic signed [DATA_W-1:0] wr_data_c;

    assign rd_sample    = bus.rd_data;
    assign win_base     = IN_AW'(32'(win_r) * 2 * IN_DIM + 32'(win_c) * 2);
    assign win_out_addr = OUT_AW'(32'(win_r) * OUT_DIM + 32'(win_c));

    // Strict greater-than so a tie keeps the earlier sample.
    assign pooled = (rd_sample > run_max) ? rd_sample : run_max;

`ifdef MAXPOOL_FUSED_RELU_EN
    assign pooled_out = pooled[DATA_W-1] ? '0 : pooled;
`else
    assign pooled_out = pooled;
`endif

    always_comb begin
        state_next = state;
        busy_c     = (state != IDLE);
        done_c     = 1'b0;
        rd_en_c    = 1'b0;
        wr_en_c    = 1'b0;
        rd_addr_c  = rd_addr_q;
        wr_addr_c  = wr_addr_q;
        wr_data_c  = wr_data_q;
        case (state)
            IDLE: begin
                if (bus.start) state_next = RD0;
            end
            RD0: begin
                rd_en_c    = 1'b1;
                rd_addr_c  = win_base;
                state_next = RD1;
            end
            RD1: begin
                rd_en_c    = 1'b1;
                rd_addr_c  = win_base + IN_AW'(1);
                state_next = RD2;
            end
            RD2: begin
                rd_en_c    = 1'b1;
                rd_addr_c  = win_base + IN_AW'(IN_DIM);
                state_next = RD3;
            end
            RD3: begin
                rd_en_c    = 1'b1;
                rd_addr_c  = win_base + IN_AW'(IN_DIM + 1);
                state_next = COMMIT;
            end
            COMMIT: begin
                wr_en_c    = 1'b1;
                wr_addr_c  = win_out_addr;
                wr_data_c  = pooled_out;
                state_next = (win_r == LAST && win_c == LAST) ? DONE : RD0;
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // rd_data lags rd_en by one cycle, so RD1 sees element 0 and COMMIT sees element 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            win_r     <= '0;
            win_c     <= '0;
            run_max   <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_next;
            rd_addr_q <= rd_addr_c;
            wr_addr_q <= wr_addr_c;
            wr_data_q <= wr_data_c;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        win_r <= '0;
                        win_c <= '0;
                    end
                end
                RD1:      run_max <= rd_sample;
                RD2, RD3: run_max <= pooled;
                COMMIT: begin
                    if (win_c == LAST) begin
                        win_c <= '0;
                        win_r <= win_r + 1'b1;
                    end else begin
                        win_c <= win_c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.rd_en   = rd_en_c;
    assign bus.rd_addr = rd_addr_c;
    assign bus.wr_en   = wr_en_c;
    assign bus.wr_addr = wr_addr_c;
    assign bus.wr_data = wr_data_c;
endmodule

// File: tb/tb_maxpool2x2_engine.sv
// Scenario-table bench for maxpool2x2_engine with a pass-level timing/data reference model.
module tb_maxpool2x2_engine;
    localparam int DATA_W  = 32;
    localparam int IN_DIM  = 6;
    localparam int IN_AW   = 6;
    localparam int OUT_AW  = 4;
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int NCYC    = 100;

    typedef struct {
        int pattern;
        int st0, st1, st2;
        int hold_until;
        int rst_cyc;
        int ps0, pa0, ps1;
    } scen_t;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxpool2x2_engine_if #(.DATA_W(DATA_W), .IN_AW(IN_AW), .OUT_AW(OUT_AW)) bus ();

    maxpool2x2_engine #(
        .DATA_W(DATA_W), .IN_DIM(IN_DIM), .IN_AW(IN_AW), .OUT_AW(OUT_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int mem [IN_DIM*IN_DIM];

    // Conv output buffer: synchronous read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en)
            bus.rd_data <= (int'(bus.rd_addr) < IN_DIM*IN_DIM) ? mem[bus.rd_addr] : 0;
    end

    int tests = 0;
    int fails = 0;
    wr_t exp_wr[$];
    wr_t obs_wr[$];
    int  exp_done[$];
    int  pass_s[$];
    int  pass_a[$];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int pool_ref(input int idx);
        int r, c, m, v;
        r = idx / OUT_DIM;
        c = idx % OUT_DIM;
        m = mem[2*r*IN_DIM + 2*c];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = mem[(2*r+dr)*IN_DIM + 2*c + dc];
                if (v > m) m = v;
            end
`ifdef MAXPOOL_FUSED_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    task automatic fill_mem(input int pattern);
        for (int i = 0; i < IN_DIM*IN_DIM; i++) begin
            case (pattern)
                0:       mem[i] = i;
                1:       mem[i] = -5;
                default: mem[i] = int'($urandom);
            endcase
        end
        if (pattern == 1) mem[7] = -2;
        if (pattern == 2) begin
            mem[3]  = int'(32'h8000_0000);
            mem[14] = int'(32'h7fff_ffff);
            mem[28] = -1;
        end
    endtask

    task automatic do_reset(input int idx);
        logic any_set;
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        any_set = bus.busy | bus.done | bus.rd_en | bus.wr_en |
                  (|bus.rd_addr) | (|bus.wr_addr) | (|bus.wr_data);
        checkOutput($sformatf("s%0d reset_state", idx), any_set, 0);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input scen_t sc, input int idx);
        int s, a, last, o, w, k, t_w, exp_wr_total, exp_done_total;
        logic exp_busy, exp_rd, any_set;
        int exp_addr;
        wr_t e;

        exp_wr.delete(); obs_wr.delete(); exp_done.delete();
        pass_s.delete(); pass_a.delete();
        if (sc.ps0 >= 0) begin pass_s.push_back(sc.ps0); pass_a.push_back(sc.pa0); end
        if (sc.ps1 >= 0) begin pass_s.push_back(sc.ps1); pass_a.push_back(-1); end
        for (int p = 0; p < pass_s.size(); p++) begin
            for (int kk = 0; kk < OUT_DIM*OUT_DIM; kk++) begin
                t_w = pass_s[p] + 5*(kk+1);
                if (pass_a[p] < 0 || t_w <= pass_a[p])
                    exp_wr.push_back('{t_w, kk, pool_ref(kk)});
            end
            if (pass_a[p] < 0) exp_done.push_back(pass_s[p] + 46);
        end
        exp_wr_total   = exp_wr.size();
        exp_done_total = exp_done.size();

        for (int t = 0; t < NCYC; t++) begin
            @(negedge clk);
            bus.start = (t == sc.st0 || t == sc.st1 || t == sc.st2 || t <= sc.hold_until);
            rst       = (t == sc.rst_cyc);

            exp_busy = 1'b0;
            exp_rd   = 1'b0;
            exp_addr = 0;
            for (int p = 0; p < pass_s.size(); p++) begin
                s    = pass_s[p];
                a    = pass_a[p];
                last = (a >= 0) ? a : s + 46;
                if (t >= s + 1 && t <= last) begin
                    exp_busy = 1'b1;
                    o = t - s - 1;
                    if (o < 45 && (o % 5) < 4) begin
                        exp_rd   = 1'b1;
                        w        = o / 5;
                        k        = o % 5;
                        exp_addr = (2*(w / OUT_DIM) + k/2) * IN_DIM + 2*(w % OUT_DIM) + k%2;
                    end
                end
            end
            checkOutput($sformatf("s%0d c%0d busy", idx, t), bus.busy, exp_busy);
            checkOutput($sformatf("s%0d c%0d rd_en", idx, t), bus.rd_en, exp_rd);
            if (exp_rd && bus.rd_en)
                checkOutput($sformatf("s%0d c%0d rd_addr", idx, t), bus.rd_addr, exp_addr);

            if (bus.wr_en) begin
                obs_wr.push_back('{t, int'(bus.wr_addr), int'(bus.wr_data)});
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    checkOutput($sformatf("s%0d wr_cycle", idx), t, e.cyc);
                    checkOutput($sformatf("s%0d c%0d wr_addr", idx, t), bus.wr_addr, e.addr);
                    checkOutput($sformatf("s%0d c%0d wr_data", idx, t), bus.wr_data, e.data);
                end
            end
            if (bus.done && exp_done.size() > 0)
                checkOutput($sformatf("s%0d done_cycle", idx), t, exp_done.pop_front());

            if (sc.rst_cyc >= 0 && t == sc.rst_cyc + 1) begin
                any_set = bus.busy | bus.done | bus.rd_en | bus.wr_en |
                          (|bus.rd_addr) | (|bus.wr_addr) | (|bus.wr_data);
                checkOutput($sformatf("s%0d post_rst_zero", idx), any_set, 0);
            end
        end
        bus.start = 1'b0;
        rst       = 1'b0;

        checkOutput($sformatf("s%0d write_count", idx), obs_wr.size(), exp_wr_total);
        checkOutput($sformatf("s%0d done_count", idx), exp_done_total - exp_done.size(),
                    exp_done_total);
    endtask

    // Counts done pulses independently of the expected-done queue.
    int done_seen;
    always @(negedge clk) if (bus.done) done_seen++;

    scen_t table_v[8];
    int    ramp_exp[9];
    int    done_before;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //            pat st0 st1 st2 hold rst  ps0 pa0 ps1
        table_v[0] = '{0,  0, -1, -1, -1, -1,   0, -1, -1};
        table_v[1] = '{1,  0, -1, -1, -1, -1,   0, -1, -1};
        table_v[2] = '{0,  0, 10, 46, -1, -1,   0, -1, -1};
        table_v[3] = '{0,  0, 25, -1, -1, 20,   0, 20, 25};
        table_v[4] = '{0, -1, -1, -1, 93, -1,   0, -1, 47};
        table_v[5] = '{2,  0, -1, -1, -1, -1,   0, -1, -1};
        table_v[6] = '{2,  5, 10, -1, -1,  5,  10, -1, -1};
        table_v[7] = '{2,  3, 30, -1, -1, -1,   3, -1, -1};
        ramp_exp   = '{7, 9, 11, 19, 21, 23, 31, 33, 35};

        done_seen = 0;
        rst       = 1'b1;
        bus.start = 1'b0;

        for (int i = 0; i < 8; i++) begin
            fill_mem(table_v[i].pattern);
            do_reset(i);
            done_before = done_seen;
            applyStimulus(table_v[i], i);
            checkOutput($sformatf("s%0d done_pulses", i), done_seen - done_before,
                        (table_v[i].pa0 < 0 ? 1 : 0) + (table_v[i].ps1 >= 0 ? 1 : 0));

            if (i == 0 && obs_wr.size() >= 9)
                for (int k = 0; k < 9; k++)
                    checkOutput($sformatf("ramp out%0d", k), obs_wr[k].data, ramp_exp[k]);

            if (i == 1 && obs_wr.size() >= 9)
                for (int k = 0; k < 9; k++) begin
`ifdef MAXPOOL_FUSED_RELU_EN
                    checkOutput($sformatf("neg out%0d", k), obs_wr[k].data, 0);
`else
                    checkOutput($sformatf("neg out%0d", k), obs_wr[k].data, (k == 0) ? -2 : -5);
`endif
                end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/maxpool2x2_engine.md
Name: maxpool2x2_engine

Overview:
- Layer-engine responder for the top-level sequencer's one-cycle start / one-cycle done handshake.
- Reads a 6x6 signed feature map from the conv output buffer through a synchronous read port.
- Computes a 2x2, stride-2 max pool and writes the 3x3 result through a write port.
- Pulses done when all 9 results are written; sits between the conv engine buffer and the FC layer input buffer.

Parameters:
- DATA_W, 32, signed data width of feature-map elements.
- IN_DIM, 6, input map side length; must be even; OUT_DIM = IN_DIM/2 (derived, not overridable).
- IN_AW, 6, input address width; must satisfy 2^IN_AW >= IN_DIM*IN_DIM.
- OUT_AW, 4, output address width; must satisfy 2^OUT_AW >= OUT_DIM*OUT_DIM.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request pulse from the sequencer; honoured only in IDLE.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- rd_en  output  1  input buffer read strobe.
- rd_addr  output  IN_AW  row-major input address, row*IN_DIM+col.
- rd_data  input  DATA_W  signed read data, valid exactly one cycle after rd_en.
- wr_en  output  1  output buffer write strobe.
- wr_addr  output  OUT_AW  row-major output address, r*OUT_DIM+c.
- wr_data  output  DATA_W  signed pooled result.

Behaviour:
- Reset values: rst clears every output to 0 (busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data). FSM goes to IDLE; the window counters and the running max clear.
- FSM states: IDLE, RD0, RD1, RD2, RD3, COMMIT, DONE.
- IDLE: on start=1, latch r=0, c=0 and go to RD0. Otherwise stay.
- RDk (k = 0..3):
  - rd_en=1; rd_addr = window element k.
  - Element order: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - In RD1, capture rd_data as the running max (first sample, not 0).
  - In RD2 and RD3, running max = signed max(running max, rd_data).
- COMMIT:
  - rd_en=0; wr_en=1; wr_addr = r*OUT_DIM+c; wr_data = signed max(running max, rd_data).
  - Advance c. On c wrap, c=0 and r increments.
  - After the last window (r=c=OUT_DIM-1), go to DONE; otherwise go to RD0.
- DONE: done=1 for exactly one cycle, busy still 1; then IDLE.
- Outside the states above, rd_en=0 and wr_en=0. rd_addr, wr_addr and wr_data hold their last values.
- Timing:
  - Each window takes 5 cycles; 9 windows take 45 cycles.
  - If start is sampled in cycle 0, the first rd_en is in cycle 1, the last wr_en is in cycle 45, and done is in cycle 46.
- Arithmetic: comparisons are signed two's complement over DATA_W; there is no saturation or rounding. Ties keep the earlier value, which gives an identical result.
- Boundary conditions:
  - start while busy (including the DONE cycle) is ignored with no effect.
  - start held high continuously: a new pass begins the cycle after DONE, since IDLE sees start=1.
  - rst mid-operation: immediate return to IDLE. No further reads or writes occur and no done is issued. Partially written output buffer contents are left as-is.
  - rst and start in the same cycle: rst wins.
  - An all-negative window yields a negative result.
  - Exactly one write per output address per pass, in ascending address order 0..8.

Optional Feature:
- Macro MAXPOOL_FUSED_RELU_EN.
- Defined: wr_data is clamped to 0 when the pooled max is negative (fused ReLU). Timing is unchanged.
- Undefined: wr_data is the raw signed max.

Test Plan:
- Ramp map, element value = address (0..35), start pulse in cycle 0:
  - Required writes, addresses 0..8 in order: 7, 9, 11, 19, 21, 23, 31, 33, 35.
  - done only in cycle 46; busy high in cycles 1..46.
- All elements = -5 except input address 7 = -2, macro undefined:
  - Output 0 = -2; outputs 1..8 = -5.
  - Same stimulus with MAXPOOL_FUSED_RELU_EN defined: all outputs = 0.
- Ramp map; extra start pulses in cycles 10 and 46: exactly 9 writes and a single done in cycle 46. No second pass.
- Ramp map; rst asserted in cycle 20:
  - No wr_en or done after cycle 20; all outputs 0 in cycle 21.
  - A new start in cycle 25 completes with done in cycle 71 and correct results.
- start held high from cycle 0: two consecutive passes; done in cycles 46 and 93, each pass preceded by one IDLE cycle.
